cla_seq_adder: RTL and testbench

Multi-cycle WIDTH-bit add/subtract unit that time-shares a single 4-bit carry-lookahead slice across the operand, one nibble per cycle, least-significant nibble first. A small FSM sequences the slice and registers the inter-slice carry. Valid/ready handshakes on input and output let it sit between operand sources and the nxm multiplier/accumulator paths. It trades latency for area against a full-width adder.

---
 rtl/cla_seq_pkg.sv | 28 ++
 rtl/cla_seq_adder_if.sv | 36 +++
 rtl/cla_seq_adder_cla4.sv | 44 ++++
 rtl/cla_seq_adder.sv | 175 +++++++++++++++++
 tb/tb_cla_seq_adder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cla_seq_pkg.sv
// -----------------------------------------------------------------------------
// cla_seq_pkg
// Shared definitions for the nibble-serial carry-lookahead add/subtract unit:
//   - state_t      : sequencer states (IDLE, RUN, DONE)
//   - SLICE_W      : width of the time-shared lookahead slice
//   - num_slices() : number of slice cycles for a given operand width
//   - idx_width()  : width of the slice index register for a given operand width
// -----------------------------------------------------------------------------
package cla_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

  // At least one bit so the index register never collapses to zero width.
  function automatic int idx_width(input int width);
    return (num_slices(width) > 1) ? $clog2(num_slices(width)) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// -----------------------------------------------------------------------------
// cla_seq_adder_if
// Operand/result handshake bundle for cla_seq_adder.
//   Input side : in_valid, in_ready, a, b, sub   (sub: 0 = a+b, 1 = a-b)
//   Output side: out_valid, out_ready, sum, cout, ovf
// Modports:
//   master : operand producer / result consumer
//   slave  : the adder
// -----------------------------------------------------------------------------
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cla_seq_adder_cla4.sv
// -----------------------------------------------------------------------------
// cla4
// Combinational 4-bit carry-lookahead slice.
//   A, B : nibble operands
//   Ci   : carry in
//   S    : nibble sum
//   Co   : carry out
//   PG   : group propagate (all four bits propagate)
//   GG   : group generate (slice generates a carry regardless of Ci)
// -----------------------------------------------------------------------------
module cla4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] S,
  output logic       Co,
  output logic       PG,
  output logic       GG
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = A ^ B;
  assign w_g = A & B;

  // Every carry is a flat sum-of-products of Ci, p and g: no ripple inside
  // the slice.
  assign w_c[0] = Ci;
  assign w_c[1] = w_g[0] | (w_p[0] & Ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Ci);
  assign w_c[4] = GG | (PG & Ci);

  assign PG = &w_p;
  assign GG = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  assign S  = w_p ^ w_c[3:0];
  assign Co = w_c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
// WIDTH-bit add/subtract unit that time-shares one 4-bit carry-lookahead slice
// across the operands, least-significant nibble first, one nibble per cycle.
// The inter-slice carry is registered, so the critical path is one cla4 plus
// the nibble mux selected by the slice index.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (discards any operation in flight)
//   bus : cla_seq_adder_if.slave
//           in_valid/in_ready  accept a, b, sub while IDLE
//           out_valid/out_ready present sum, cout, ovf while DONE
//
// Subtract is done as a + ~b + 1: b is inverted on accept and the initial
// carry is the sub bit, so cout = 1 on subtract means "no borrow".
// -----------------------------------------------------------------------------
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  cla_seq_adder_if.slave   bus
);

  localparam int K     = num_slices(WIDTH);
  localparam int IDX_W = idx_width(WIDTH);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                         r_state;
  state_t                         w_state_nxt;

  // Operands and result are held as arrays of nibbles so the slice index
  // selects a nibble directly.
  logic [K-1:0][SLICE_W-1:0]      r_a;
  logic [K-1:0][SLICE_W-1:0]      r_b;
  logic [K-1:0][SLICE_W-1:0]      r_sum;
  logic                           r_carry;
  logic                           r_cout;
  logic                           r_ovf;
  logic [IDX_W-1:0]               r_idx;

  logic                           w_in_ready;
  logic                           w_out_valid;
  logic                           w_accept;
  logic                           w_run;
  logic                           w_last;

  logic [SLICE_W-1:0]             w_a_nib;
  logic [SLICE_W-1:0]             w_b_nib;
  logic [SLICE_W-1:0]             w_s_nib;
  logic                           w_co;
  logic                           w_ovf;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // in_ready stays low here: a result handoff and a new accept never
        // share a cycle.
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_run    = (r_state == RUN);
  assign w_last   = (r_idx == IDX_W'(K - 1));

  // ---------------------------------------------------------------------------
  // Slice datapath
  // ---------------------------------------------------------------------------
  assign w_a_nib = r_a[r_idx];
  assign w_b_nib = r_b[r_idx];

  cla4 u_cla4 (
    .A  (w_a_nib),
    .B  (w_b_nib),
    .Ci (r_carry),
    .S  (w_s_nib),
    .Co (w_co),
    .PG (),
    .GG ()
  );

  // Signed overflow: both effective operands share a sign and the result sign
  // differs. r_b is already inverted for subtract, so one rule covers both.
  assign w_ovf = (r_a[K-1][SLICE_W-1] == r_b[K-1][SLICE_W-1]) &&
                 (w_s_nib[SLICE_W-1] != r_a[K-1][SLICE_W-1]);

  // NOTE: the operand registers carry no reset; they are always loaded on
  // accept before the slice reads them, and they are never visible outside.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.a;
      r_b <= bus.sub ? ~bus.b : bus.b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_carry <= bus.sub;
      r_idx   <= '0;
    end else if (w_run) begin
      r_sum[r_idx] <= w_s_nib;
      r_carry      <= w_co;
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= w_ovf;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_cla_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_seq_adder
// Self-checking bench for cla_seq_adder (WIDTH=16). Results are compared with
// a plain integer-arithmetic model of add/subtract, carry/borrow and signed
// overflow. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cla_seq_adder;

  localparam int WIDTH = 16;
  localparam int K     = WIDTH / 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla_seq_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic s);
    int          sa = $signed(a);
    int          sb = $signed(b);
    int          sr;
    int unsigned ua = a;
    int unsigned ub = b;
    logic [WIDTH-1:0] rs;
    logic rc;
    logic ro;
    if (!s) begin
      sr = sa + sb;
      rs = WIDTH'(ua + ub);
      rc = (ua + ub) > 32'h0000_FFFF;
    end else begin
      sr = sa - sb;
      rs = WIDTH'(ua - ub);
      rc = (ua >= ub);
    end
    ro = (sr > 32767) || (sr < -32768);
    return {ro, rc, rs};
  endfunction

  // One full transaction: accept, latency check, result check, optional
  // back-pressure with noise on the input side, then release.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input int hold, input string tag);
    logic [WIDTH+1:0] exp;
    int lat;
    exp = model(a, b, s);

    @(negedge clk);
    check({tag, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.sub       = s;
    bus.out_ready = 1'b0;

    @(negedge clk);  // accept edge has passed
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    bus.sub      = 1'($urandom);
    check({tag, "/in_ready_run"}, 32'(bus.in_ready), 32'd0);

    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(K));
    if (!bus.out_valid) return;

    check({tag, "/sum"},  32'(bus.sum),  32'(exp[WIDTH-1:0]));
    check({tag, "/cout"}, 32'(bus.cout), 32'(exp[WIDTH]));
    check({tag, "/ovf"},  32'(bus.ovf),  32'(exp[WIDTH+1]));

    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a        = WIDTH'($urandom);
      bus.b        = WIDTH'($urandom);
      bus.sub      = 1'($urandom);
      @(negedge clk);
      check({tag, "/hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "/hold_ready"}, 32'(bus.in_ready),  32'd0);
      check({tag, "/hold_sum"},   32'(bus.sum),       32'(exp[WIDTH-1:0]));
      check({tag, "/hold_flags"}, 32'({bus.ovf, bus.cout}),
            32'(exp[WIDTH+1:WIDTH]));
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "/release_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "/release_idle"},  32'(bus.in_ready),  32'd1);
  endtask

  task automatic reset_mid_run();
    logic seen;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h1111;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);  // RUN cycle 1
    bus.in_valid = 1'b0;
    @(negedge clk);  // RUN cycle 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run/in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_run/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_run/sum",       32'(bus.sum),       32'd0);
    check("rst_run/flags",     32'({bus.ovf, bus.cout}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_run/no_output", 32'(seen), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/in_ready",  32'(bus.in_ready),  32'd1);
    check("reset/out_valid", 32'(bus.out_valid), 32'd0);
    check("reset/sum",       32'(bus.sum),       32'd0);
    check("reset/cout",      32'(bus.cout),      32'd0);
    check("reset/ovf",       32'(bus.ovf),       32'd0);
    rst = 1'b0;

    do_op(16'h1234, 16'h4321, 1'b0, 0,  "add_basic");
    do_op(16'hFFFF, 16'h0001, 1'b0, 0,  "add_carry_chain");
    do_op(16'h7FFF, 16'h0001, 1'b0, 0,  "add_pos_ovf");
    do_op(16'h8000, 16'h8000, 1'b0, 0,  "add_neg_ovf");
    do_op(16'h0005, 16'h0007, 1'b1, 0,  "sub_borrow");
    do_op(16'h8000, 16'h0001, 1'b1, 0,  "sub_ovf");
    do_op(16'hA5C3, 16'h1E0F, 1'b1, 10, "backpressure");
    do_op(16'h0F0F, 16'h00F1, 1'b0, 0,  "after_backpressure");

    reset_mid_run();
    do_op(16'h4000, 16'h4000, 1'b0, 0,  "after_reset");

    for (int i = 0; i < 40; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
